sd_cmd_tx: RTL and testbench

//  Transmit side of the SD-card host link. Builds a 48-bit SD command frame

---
 rtl/sd_cmd_tx.sv | 237 +++++++++++++++++++++++
 tb/tb_sd_cmd_tx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_tx.sv
// sd_cmd_tx: SD host command transmitter.
// Builds a 48-bit command frame: start 0, tx 1, index, argument, CRC7, end 1.
// The frame goes out MSB first on CMD, and the block generates its own SDCLK.
// After the end bit, TRAIL_CLKS more SDCLK periods run with CMD released.
// Then done pulses and the block returns to idle.
module sd_cmd_tx #(
    parameter int TRAIL_CLKS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic [1:0]  speed,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic        sdclk,
    output logic        cmd_out,
    output logic        cmd_oe
);

    localparam int TW = (TRAIL_CLKS > 1) ? $clog2(TRAIL_CLKS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND  = 3'd1,
        ST_CRC   = 3'd2,
        ST_END   = 3'd3,
        ST_TRAIL = 3'd4
    } state_t;

    // One serial CRC7 step for x^7 + x^3 + 1
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // SDCLK period in system clocks; code 11 behaves like 00
    function automatic logic [2:0] period_of(input logic [1:0] spd);
        case (spd)
            2'b01:   return 3'd3;
            2'b10:   return 3'd2;
            default: return 3'd6;
        endcase
    endfunction

    // SDCLK high time in system clocks
    function automatic logic [2:0] high_of(input logic [1:0] spd);
        case (spd)
            2'b01:   return 3'd2;
            2'b10:   return 3'd1;
            default: return 3'd3;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [1:0]      speed_q, speed_d;
    logic [2:0]      phase_q, phase_d;
    logic [5:0]      bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]   trail_cnt_q, trail_cnt_d;
    logic [38:0]     sh_q, sh_d;        // frame bits 46..8; the start bit is sent directly
    logic [6:0]      crc_q, crc_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            sdclk_q, sdclk_d;
    logic            cmd_out_q, cmd_out_d;
    logic            cmd_oe_q, cmd_oe_d;

    logic [2:0]      per_s;
    logic [2:0]      hi_s;
    logic [2:0]      phase_inc_s;
    logic            boundary_s;
    logic [5:0]      bit_nxt_s;

    // Next-state and next-output logic for the whole transmitter
    always_comb begin
        state_d     = state_q;
        speed_d     = speed_q;
        phase_d     = phase_q;
        bit_cnt_d   = bit_cnt_q;
        trail_cnt_d = trail_cnt_q;
        sh_d        = sh_q;
        crc_d       = crc_q;
        ready_d     = ready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        sdclk_d     = sdclk_q;
        cmd_out_d   = cmd_out_q;
        cmd_oe_d    = cmd_oe_q;

        per_s       = period_of(speed_q);
        hi_s        = high_of(speed_q);
        phase_inc_s = (phase_q == (per_s - 3'd1)) ? 3'd0 : (phase_q + 3'd1);
        // A bit boundary is the system-clock edge on which SDCLK falls.
        boundary_s  = (state_q != ST_IDLE) && (phase_inc_s == hi_s);
        bit_nxt_s   = bit_cnt_q + 6'd1;

        if (state_q != ST_IDLE) begin
            phase_d = phase_inc_s;
            sdclk_d = (phase_inc_s < hi_s);
        end else begin
            phase_d = phase_q;
            sdclk_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    speed_d     = speed;
                    phase_d     = high_of(speed);
                    sh_d        = {1'b1, cmd_index, cmd_arg};
                    crc_d       = 7'h00;
                    bit_cnt_d   = 6'd0;
                    trail_cnt_d = '0;
                    state_d     = ST_SEND;
                    cmd_out_d   = 1'b0;
                    cmd_oe_d    = 1'b1;
                    ready_d     = 1'b0;
                    busy_d      = 1'b1;
                end else begin
                    cmd_out_d   = 1'b1;
                    cmd_oe_d    = 1'b0;
                    ready_d     = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            ST_SEND: begin
                if (boundary_s) begin
                    bit_cnt_d = bit_nxt_s;
                    if (bit_nxt_s == 6'd40) begin
                        // The CRC already covers bits 47..8, so its MSB goes out now.
                        state_d   = ST_CRC;
                        cmd_out_d = crc_q[6];
                        crc_d     = {crc_q[5:0], 1'b0};
                    end else begin
                        cmd_out_d = sh_q[38];
                        sh_d      = {sh_q[37:0], 1'b0};
                        crc_d     = crc7_step(crc_q, sh_q[38]);
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
            end
            ST_CRC: begin
                if (boundary_s) begin
                    bit_cnt_d = bit_nxt_s;
                    if (bit_nxt_s == 6'd47) begin
                        state_d   = ST_END;
                        cmd_out_d = 1'b1;
                    end else begin
                        cmd_out_d = crc_q[6];
                        crc_d     = {crc_q[5:0], 1'b0};
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
            end
            ST_END: begin
                if (boundary_s) begin
                    state_d     = ST_TRAIL;
                    trail_cnt_d = '0;
                    cmd_oe_d    = 1'b0;
                    cmd_out_d   = 1'b1;
                end else begin
                    trail_cnt_d = trail_cnt_q;
                end
            end
            ST_TRAIL: begin
                if (boundary_s) begin
                    if (trail_cnt_q == TW'(TRAIL_CLKS - 1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        sdclk_d = 1'b0;
                    end else begin
                        trail_cnt_d = trail_cnt_q + TW'(1);
                    end
                end else begin
                    trail_cnt_d = trail_cnt_q;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                ready_d   = 1'b1;
                busy_d    = 1'b0;
                sdclk_d   = 1'b0;
                cmd_out_d = 1'b1;
                cmd_oe_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset to the idle line state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            speed_q     <= 2'b00;
            phase_q     <= 3'd0;
            bit_cnt_q   <= 6'd0;
            trail_cnt_q <= '0;
            sh_q        <= 39'd0;
            crc_q       <= 7'h00;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sdclk_q     <= 1'b0;
            cmd_out_q   <= 1'b1;
            cmd_oe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            speed_q     <= speed_d;
            phase_q     <= phase_d;
            bit_cnt_q   <= bit_cnt_d;
            trail_cnt_q <= trail_cnt_d;
            sh_q        <= sh_d;
            crc_q       <= crc_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            sdclk_q     <= sdclk_d;
            cmd_out_q   <= cmd_out_d;
            cmd_oe_q    <= cmd_oe_d;
        end
    end

    assign ready   = ready_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign sdclk   = sdclk_q;
    assign cmd_out = cmd_out_q;
    assign cmd_oe  = cmd_oe_q;

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Testbench for sd_cmd_tx.
// Applies a table of known commands and hand-built corner sequences.
// Also sends random commands, checked against a frame/timing model.
module tb_sd_cmd_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic [1:0]  speed;
    logic        ready, busy, done, sdclk, cmd_out, cmd_oe;

    int checks = 0;
    int errors = 0;

    sd_cmd_tx #(.TRAIL_CLKS(8)) dut (
        .clk(clk), .rst(rst), .start(start), .cmd_index(cmd_index),
        .cmd_arg(cmd_arg), .speed(speed), .ready(ready), .busy(busy),
        .done(done), .sdclk(sdclk), .cmd_out(cmd_out), .cmd_oe(cmd_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [1:0]  spd;
        logic [47:0] frame;
        int          done_at;   // cycles after the accept cycle T
        int          disturb;   // 0 none, 1 speed toggling, 2 start pulse at bit 20
    } vec_t;

    vec_t vec[6];

    function automatic int per_of(input logic [1:0] s);
        return (s == 2'b01) ? 3 : (s == 2'b10) ? 2 : 6;
    endfunction

    function automatic int hi_of(input logic [1:0] s);
        return (s == 2'b01) ? 2 : (s == 2'b10) ? 1 : 3;
    endfunction

    // CRC7 as the remainder of m(x)*x^7 divided by x^7+x^3+1
    function automatic logic [6:0] model_crc(input logic [39:0] m);
        logic [46:0] r;
        r = {m, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    function automatic logic [47:0] model_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] m;
        m = {2'b01, idx, arg};
        return {m, model_crc(m), 1'b1};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Sends one command and checks every cycle until done.
    // Called at a point #1 after a clock edge, with ready=1.
    task automatic send_frame(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] spd,
                              input logic [47:0] exp_frame, input int exp_done, input int disturb,
                              input string tag);
        int p, h, done_c, wave_err;
        logic [47:0] cap;
        logic [5:0] expv, actv;
        p = per_of(spd);
        h = hi_of(spd);
        cmd_index = idx; cmd_arg = arg; speed = spd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done_c = -1; wave_err = 0; cap = '0;
        for (int c = 0; c < 700; c++) begin
            if (c >= exp_done - 1) begin
                expv = 6'b101010;
            end else begin
                expv[5] = 1'b0;
                expv[4] = 1'b1;
                expv[3] = 1'b0;
                expv[2] = (((h + c) % p) < h);
                expv[1] = (c < 48 * p) ? exp_frame[47 - c / p] : 1'b1;
                expv[0] = (c < 48 * p);
            end
            actv = {ready, busy, done, sdclk, cmd_out, cmd_oe};
            if (actv !== expv) begin
                if (wave_err < 3) $display("FAIL %s_wave c=%0d actual=%b expected=%b", tag, c, actv, expv);
                wave_err++;
            end
            // the card samples CMD on the SDCLK rising edge
            if (c < 48 * p && (c % p) == p - h) cap = {cap[46:0], cmd_out};
            if (done === 1'b1) begin
                done_c = c;
                break;
            end
            if (disturb == 1) speed = 2'($urandom);
            if (disturb == 2) begin
                start = (c == 20 * p);
                cmd_index = 6'd55;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk({tag, "_serial"}, 64'(cap), 64'(exp_frame));
        chk({tag, "_done_at"}, 64'(done_c + 1), 64'(exp_done));
        chk({tag, "_wave_errs"}, 64'(wave_err), 64'd0);
    endtask

    // Expects a quiet idle line for n cycles: ready held, no done pulse
    task automatic idle_check(input int n, input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || ready !== 1'b1 || sdclk !== 1'b0) bad++;
        end
        chk(tag, 64'(bad), 64'd0);
    endtask

    initial begin
        logic [5:0]  ri;
        logic [31:0] ra;
        logic [1:0]  rs;

        vec[0] = '{6'd0,  32'h0000_0000, 2'b10, 48'h4000_0000_0095, 113, 0};
        vec[1] = '{6'd8,  32'h0000_01AA, 2'b00, 48'h4800_0001_AA87, 337, 0};
        vec[2] = '{6'd17, 32'h0000_0000, 2'b01, 48'h5100_0000_0055, 169, 0};
        vec[3] = '{6'd8,  32'h0000_01AA, 2'b11, 48'h4800_0001_AA87, 337, 0};
        vec[4] = '{6'd8,  32'h0000_01AA, 2'b00, 48'h4800_0001_AA87, 337, 1};
        vec[5] = '{6'd17, 32'h0000_0000, 2'b01, 48'h5100_0000_0055, 169, 2};

        rst = 1'b1; start = 1'b0; cmd_index = 6'd0; cmd_arg = 32'd0; speed = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 64'({ready, busy, done, sdclk, cmd_out, cmd_oe}), 64'(6'b100010));
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            send_frame(vec[i].idx, vec[i].arg, vec[i].spd, vec[i].frame,
                       vec[i].done_at, vec[i].disturb, $sformatf("vec%0d", i));
            if (vec[i].disturb == 2) idle_check(8, "ignored_start_no_extra");
            else begin @(posedge clk); #1; end
        end

        // back-to-back: the next start is raised in the done cycle itself
        send_frame(6'd0, 32'd0, 2'b10, 48'h4000_0000_0095, 113, 0, "b2b_a");
        send_frame(6'd8, 32'h1AA, 2'b00, 48'h4800_0001_AA87, 337, 0, "b2b_b");
        send_frame(6'd17, 32'd0, 2'b01, 48'h5100_0000_0055, 169, 0, "b2b_c");

        // reset in the middle of a frame
        cmd_index = 6'd0; cmd_arg = 32'd0; speed = 2'b10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        chk("midframe_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midframe_rst_outputs", 64'({ready, busy, done, sdclk, cmd_out, cmd_oe}), 64'(6'b100010));
        rst = 1'b0;
        idle_check(10, "after_rst_no_done");
        send_frame(6'd0, 32'd0, 2'b10, 48'h4000_0000_0095, 113, 0, "after_rst_cmd0");
        @(posedge clk); #1;

        // random commands against the model
        for (int k = 0; k < 6; k++) begin
            ri = 6'($urandom);
            ra = $urandom;
            rs = 2'($urandom_range(0, 3));
            send_frame(ri, ra, rs, model_frame(ri, ra), 1 + 56 * per_of(rs),
                       0, $sformatf("rand%0d", k));
            if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
